// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV32 byte/half/word load-store sequencer in front of a
//               word-wide data memory (sub-word stores use read-modify-write).
// Revision    : 1.0 - initial release
// ============================================================================

module load_store_unit #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              fault,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    state_t              state_q;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [1:0]          off_q;
    logic [15:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic [31:0]         mem_wdata_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                fault_q;

    logic                w_acc_fault;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_ext;
    logic [31:0]         w_merge;

    // Illegal width code or misaligned address, judged on the request inputs
    always_comb begin
        w_acc_fault = 1'b0;
        if (we) begin
            case (funct3)
                c_F3_B:  w_acc_fault = 1'b0;
                c_F3_H:  w_acc_fault = addr[0];
                c_F3_W:  w_acc_fault = |addr[1:0];
                default: w_acc_fault = 1'b1;
            endcase
        end else begin
            case (funct3)
                c_F3_B, c_F3_BU: w_acc_fault = 1'b0;
                c_F3_H, c_F3_HU: w_acc_fault = addr[0];
                c_F3_W:          w_acc_fault = |addr[1:0];
                default:         w_acc_fault = 1'b1;
            endcase
        end
    end

    // Little-endian lane selection from the memory word
    always_comb begin
        w_byte = mem_rdata[7:0];
        case (off_q)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        w_load_ext = mem_rdata;
        case (f3_q)
            c_F3_B:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            c_F3_H:  w_load_ext = {{16{w_half[15]}}, w_half};
            c_F3_BU: w_load_ext = {24'd0, w_byte};
            c_F3_HU: w_load_ext = {16'd0, w_half};
            default: w_load_ext = mem_rdata;
        endcase
    end

    // Sub-word store: replace only the addressed lane of the word just read
    always_comb begin
        w_merge = mem_rdata;
        if (f3_q == c_F3_B) begin
            case (off_q)
                2'd0:    w_merge[7:0]   = wdata_q[7:0];
                2'd1:    w_merge[15:8]  = wdata_q[7:0];
                2'd2:    w_merge[23:16] = wdata_q[7:0];
                default: w_merge[31:24] = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            w_merge[31:16] = wdata_q;
        end else begin
            w_merge[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            wdata_q     <= 16'd0;
            rdata_q     <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_addr_q  <= '0;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q       <= we;
                        f3_q       <= funct3;
                        off_q      <= addr[1:0];
                        wdata_q    <= wdata[15:0];
                        mem_addr_q <= {addr[ADDR_W-1:2], 2'b00};
                        if (w_acc_fault) begin
                            fault_q <= 1'b1;
                            state_q <= S_DONE;
                        end else if (we && (funct3 == c_F3_W)) begin
                            mem_wdata_q <= wdata;
                            state_q     <= S_WR;
                        end else begin
                            state_q <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (we_q) begin
                        mem_wdata_q <= w_merge;
                        state_q     <= S_WR;
                    end else begin
                        rdata_q <= w_load_ext;
                        state_q <= S_DONE;
                    end
                end
                S_WR: begin
                    mem_wdata_q <= 32'd0;
                    state_q     <= S_DONE;
                end
                default: begin
                    fault_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign mem_read  = (state_q == S_RD);
    assign mem_write = (state_q == S_WR);
    assign fault     = fault_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit against a byte-array
//               memory model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_load_store_unit;

    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              reset_r = 1'b1;
    logic              req_r = 1'b0;
    logic              we_r = 1'b0;
    logic [2:0]        f3_r = 3'd0;
    logic [ADDR_W-1:0] addr_r = '0;
    logic [31:0]       wdata_r = 32'd0;
    logic              ready, done, fault, mem_read, mem_write;
    logic [31:0]       rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    logic [31:0] tb_mem [0:127];
    logic [7:0]  ref_mem [0:511];
    logic        load_init = 1'b0;
    logic [31:0] exp_rdata = 32'd0;

    int checks = 0;
    int failures = 0;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset_r), .req(req_r), .we(we_r), .funct3(f3_r),
        .addr(addr_r), .wdata(wdata_r), .ready(ready), .done(done),
        .rdata(rdata), .fault(fault), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_word(input logic [8:0] a);
        logic [8:0] b;
        b = {a[8:2], 2'b00};
        return {ref_mem[b + 9'd3], ref_mem[b + 9'd2], ref_mem[b + 9'd1], ref_mem[b]};
    endfunction

    // Data memory: combinational read, write on the clock edge
    assign mem_rdata = tb_mem[mem_addr[8:2]];
    always @(posedge clk) begin
        if (load_init) begin
            for (int i = 0; i < 128; i++) tb_mem[i] <= ref_word(9'(i * 4));
        end else if (mem_write) begin
            tb_mem[mem_addr[8:2]] <= mem_wdata;
        end
    end

    function automatic bit exp_fault(input bit w, input logic [2:0] f, input logic [8:0] a);
        if (w) return (f >= 3'd3) || (f == 3'd1 && a[0]) || (f == 3'd2 && a[1:0] != 2'd0);
        return (f == 3'd3) || (f == 3'd6) || (f == 3'd7) ||
               ((f == 3'd1 || f == 3'd5) && a[0]) || (f == 3'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f, input logic [8:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = ref_mem[a]; b1 = ref_mem[a + 9'd1]; b2 = ref_mem[a + 9'd2]; b3 = ref_mem[a + 9'd3];
        case (f)
            3'd0:    return {{24{b0[7]}}, b0};
            3'd1:    return {{16{b1[7]}}, b1, b0};
            3'd4:    return {24'd0, b0};
            3'd5:    return {16'd0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    task automatic apply_store(input logic [2:0] f, input logic [8:0] a, input logic [31:0] d);
        ref_mem[a] = d[7:0];
        if (f != 3'd0) ref_mem[a + 9'd1] = d[15:8];
        if (f == 3'd2) begin
            ref_mem[a + 9'd2] = d[23:16];
            ref_mem[a + 9'd3] = d[31:24];
        end
    endtask

    // Issues one request when ready and observes the strobes up to done
    task automatic run_access(input bit w, input logic [2:0] f, input logic [8:0] a,
                              input logic [31:0] d, output int lat, output int nrd,
                              output int nwr, output int nboth, output int nwd,
                              output logic [31:0] wdat, output logic [8:0] waddr,
                              output logic flt, output logic [31:0] rdv, output bit tout);
        int k;
        lat = 0; nrd = 0; nwr = 0; nboth = 0; nwd = 0; wdat = 32'd0; waddr = '0;
        flt = 1'b0; rdv = 32'd0; tout = 1'b0; k = 0;
        @(negedge clk);
        while (!ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!ready) begin
            tout = 1'b1;
            return;
        end
        req_r = 1'b1; we_r = w; f3_r = f; addr_r = a; wdata_r = d;
        @(negedge clk);
        req_r = 1'b0; we_r = 1'($urandom); f3_r = 3'($urandom);
        addr_r = 9'($urandom); wdata_r = $urandom;
        lat = 1;
        while (lat <= 10) begin
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++;
                wdat = mem_wdata;
                waddr = mem_addr;
            end else if (mem_wdata != 32'd0) begin
                nwd++;
            end
            if (mem_read && mem_write) nboth++;
            if (done) begin
                flt = fault;
                rdv = rdata;
                return;
            end
            @(negedge clk);
            lat++;
        end
        tout = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        load_init = 1'b1;
        @(negedge clk);
        load_init = 1'b0;
        @(negedge clk);
        checks += 8;
        if (ready !== 1'b1)       begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        if (done !== 1'b0)        begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        if (fault !== 1'b0)       begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
        if (rdata !== 32'd0)      begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        if (mem_read !== 1'b0)    begin failures++; $display("FAIL reset_mem_read got=%b exp=0", mem_read); end
        if (mem_write !== 1'b0)   begin failures++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
        if (mem_addr !== 9'd0)    begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        if (mem_wdata !== 32'd0)  begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        reset_r = 1'b0;
        exp_rdata = 32'd0;
    endtask

    task automatic test_load_extend();
        int lat, nrd, nwr, nb, nwd; logic [31:0] wd, rv; logic [8:0] wa; logic fl; bit to;
        run_access(1'b0, 3'b000, 9'h012, 32'h0, lat, nrd, nwr, nb, nwd, wd, wa, fl, rv, to);
        checks += 4;
        if (to || rv !== 32'hFFFFFF99) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff99 to=%0b", rv, to); end
        if (lat != 2) begin failures++; $display("FAIL lb_latency got=%0d exp=2", lat); end
        if (fl !== 1'b0) begin failures++; $display("FAIL lb_fault got=%b exp=0", fl); end
        if (nrd != 1 || nwr != 0) begin failures++; $display("FAIL lb_strobes rd=%0d wr=%0d exp rd=1 wr=0", nrd, nwr); end
        run_access(1'b0, 3'b100, 9'h013, 32'h0, lat, nrd, nwr, nb, nwd, wd, wa, fl, rv, to);
        checks += 1;
        if (to || rv !== 32'h00000088) begin failures++; $display("FAIL lbu_rdata got=%h exp=00000088", rv); end
        exp_rdata = 32'h00000088;
    endtask

    task automatic test_rmw_store();
        int lat, nrd, nwr, nb, nwd; logic [31:0] wd, rv; logic [8:0] wa; logic fl; bit to;
        run_access(1'b1, 3'b000, 9'h011, 32'h12345677, lat, nrd, nwr, nb, nwd, wd, wa, fl, rv, to);
        apply_store(3'b000, 9'h011, 32'h12345677);
        checks += 6;
        if (to || wd !== 32'h889977BB) begin failures++; $display("FAIL sb_wdata got=%h exp=889977bb", wd); end
        if (wa !== 9'h010) begin failures++; $display("FAIL sb_waddr got=%h exp=010", wa); end
        if (nrd != 1 || nwr != 1 || nb != 0) begin failures++; $display("FAIL sb_strobes rd=%0d wr=%0d both=%0d exp 1/1/0", nrd, nwr, nb); end
        if (lat != 3) begin failures++; $display("FAIL sb_latency got=%0d exp=3", lat); end
        if (rv !== exp_rdata) begin failures++; $display("FAIL sb_rdata_hold got=%h exp=%h", rv, exp_rdata); end
        if (tb_mem[4] !== 32'h889977BB) begin failures++; $display("FAIL sb_memword got=%h exp=889977bb", tb_mem[4]); end
    endtask

    task automatic test_word_store();
        int lat, nrd, nwr, nb, nwd; logic [31:0] wd, rv; logic [8:0] wa; logic fl; bit to;
        run_access(1'b1, 3'b010, 9'h020, 32'hDEADBEEF, lat, nrd, nwr, nb, nwd, wd, wa, fl, rv, to);
        apply_store(3'b010, 9'h020, 32'hDEADBEEF);
        checks += 3;
        if (to || wd !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", wd); end
        if (nrd != 0 || nwr != 1) begin failures++; $display("FAIL sw_strobes rd=%0d wr=%0d exp rd=0 wr=1", nrd, nwr); end
        if (lat != 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        run_access(1'b0, 3'b010, 9'h020, 32'h0, lat, nrd, nwr, nb, nwd, wd, wa, fl, rv, to);
        checks += 1;
        if (to || rv !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", rv); end
        run_access(1'b0, 3'b101, 9'h022, 32'h0, lat, nrd, nwr, nb, nwd, wd, wa, fl, rv, to);
        checks += 1;
        if (to || rv !== 32'h0000DEAD) begin failures++; $display("FAIL lhu_rdata got=%h exp=0000dead", rv); end
        run_access(1'b0, 3'b001, 9'h020, 32'h0, lat, nrd, nwr, nb, nwd, wd, wa, fl, rv, to);
        checks += 1;
        if (to || rv !== 32'hFFFFBEEF) begin failures++; $display("FAIL lh_rdata got=%h exp=ffffbeef", rv); end
        exp_rdata = 32'hFFFFBEEF;
    endtask

    task automatic test_fault();
        int lat, nrd, nwr, nb, nwd; logic [31:0] wd, rv; logic [8:0] wa; logic fl; bit to;
        logic [2:0]  f3s [2] = '{3'b001, 3'b011};
        logic [8:0]  as  [2] = '{9'h013, 9'h020};
        for (int i = 0; i < 2; i++) begin
            run_access(1'b0, f3s[i], as[i], 32'h0, lat, nrd, nwr, nb, nwd, wd, wa, fl, rv, to);
            checks += 4;
            if (to || fl !== 1'b1) begin failures++; $display("FAIL fault_flag[%0d] got=%b exp=1", i, fl); end
            if (lat != 1) begin failures++; $display("FAIL fault_latency[%0d] got=%0d exp=1", i, lat); end
            if (nrd != 0 || nwr != 0) begin failures++; $display("FAIL fault_strobes[%0d] rd=%0d wr=%0d exp 0/0", i, nrd, nwr); end
            if (rv !== exp_rdata) begin failures++; $display("FAIL fault_rdata[%0d] got=%h exp=%h", i, rv, exp_rdata); end
        end
    endtask

    task automatic test_reset_mid_rmw();
        int lat, nrd, nwr, nb, nwd, nw; logic [31:0] wd, rv; logic [8:0] wa; logic fl; bit to;
        nw = 0;
        @(negedge clk);
        req_r = 1'b1; we_r = 1'b1; f3_r = 3'b001; addr_r = 9'h020; wdata_r = 32'h00001234;
        @(negedge clk);
        req_r = 1'b0;
        checks += 1;
        if (mem_read !== 1'b1) begin failures++; $display("FAIL rst_rmw_in_rd got=%b exp=1", mem_read); end
        reset_r = 1'b1;
        @(negedge clk);
        reset_r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mem_write || done) nw++;
            @(negedge clk);
        end
        checks += 4;
        if (nw != 0) begin failures++; $display("FAIL rst_rmw_no_write got=%0d exp=0", nw); end
        if (ready !== 1'b1) begin failures++; $display("FAIL rst_rmw_ready got=%b exp=1", ready); end
        if (rdata !== 32'd0) begin failures++; $display("FAIL rst_rmw_rdata got=%h exp=0", rdata); end
        if (tb_mem[8] !== 32'hDEADBEEF) begin failures++; $display("FAIL rst_rmw_memword got=%h exp=deadbeef", tb_mem[8]); end
        exp_rdata = 32'd0;
        run_access(1'b0, 3'b010, 9'h020, 32'h0, lat, nrd, nwr, nb, nwd, wd, wa, fl, rv, to);
        checks += 1;
        if (to || rv !== 32'hDEADBEEF) begin failures++; $display("FAIL rst_rmw_lw got=%h exp=deadbeef", rv); end
        exp_rdata = 32'hDEADBEEF;
    endtask

    task automatic test_back_to_back();
        int acc, dn, both, badr, rdy_done;
        acc = 0; dn = 0; both = 0; badr = 0; rdy_done = 0;
        @(negedge clk);
        req_r = 1'b1; we_r = 1'b0; f3_r = 3'b010; addr_r = 9'h020; wdata_r = 32'h0;
        for (int s = 0; s < 12; s++) begin
            if (ready && req_r) acc++;
            if (done) begin
                dn++;
                if (rdata !== 32'hDEADBEEF) badr++;
            end
            if (mem_read && mem_write) both++;
            if (ready && done) rdy_done++;
            if (s == 11) req_r = 1'b0;
            @(negedge clk);
        end
        checks += 5;
        if (acc != 4) begin failures++; $display("FAIL b2b_accepts got=%0d exp=4", acc); end
        if (dn != acc) begin failures++; $display("FAIL b2b_done_per_access got=%0d exp=%0d", dn, acc); end
        if (both != 0) begin failures++; $display("FAIL b2b_rd_wr_overlap got=%0d exp=0", both); end
        if (badr != 0) begin failures++; $display("FAIL b2b_rdata bad=%0d exp=0", badr); end
        if (rdy_done != 0) begin failures++; $display("FAIL b2b_ready_in_done got=%0d exp=0", rdy_done); end
    endtask

    task automatic test_random();
        int lat, nrd, nwr, nb, nwd, elat, erd, ewr; logic [31:0] wd, rv, d; logic [8:0] wa, a;
        logic fl; bit to, w, f; logic [2:0] f3;
        for (int n = 0; n < 80; n++) begin
            w = 1'($urandom); f3 = 3'($urandom_range(0, 7)); a = 9'($urandom); d = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'd0;
            f = exp_fault(w, f3, a);
            run_access(w, f3, a, d, lat, nrd, nwr, nb, nwd, wd, wa, fl, rv, to);
            elat = f ? 1 : ((w && f3 != 3'd2) ? 3 : 2);
            erd  = (f || (w && f3 == 3'd2)) ? 0 : 1;
            ewr  = (!f && w) ? 1 : 0;
            if (!f && w) apply_store(f3, a, d);
            if (!f && !w) exp_rdata = exp_load(f3, a);
            checks += 5;
            if (to) begin failures++; $display("FAIL rnd_timeout n=%0d", n); end
            if (fl !== f) begin failures++; $display("FAIL rnd_fault n=%0d got=%b exp=%b", n, fl, f); end
            if (rv !== exp_rdata) begin failures++; $display("FAIL rnd_rdata n=%0d we=%0b f3=%0d a=%h got=%h exp=%h", n, w, f3, a, rv, exp_rdata); end
            if (lat != elat || nrd != erd || nwr != ewr) begin
                failures++; $display("FAIL rnd_timing n=%0d lat=%0d rd=%0d wr=%0d exp %0d/%0d/%0d", n, lat, nrd, nwr, elat, erd, ewr);
            end
            if (nb != 0 || nwd != 0) begin failures++; $display("FAIL rnd_strobe_rules n=%0d both=%0d wdata_nz=%0d exp 0/0", n, nb, nwd); end
            if (!f && w) begin
                checks += 1;
                if (wd !== ref_word(a) || wa !== {a[8:2], 2'b00}) begin
                    failures++; $display("FAIL rnd_store n=%0d got=%h@%h exp=%h@%h", n, wd, wa, ref_word(a), {a[8:2], 2'b00});
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'($urandom);
        ref_mem[9'h010] = 8'hBB; ref_mem[9'h011] = 8'hAA;
        ref_mem[9'h012] = 8'h99; ref_mem[9'h013] = 8'h88;
        test_reset();
        test_load_extend();
        test_rmw_store();
        test_word_store();
        test_fault();
        test_reset_mid_rmw();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning the byte-address width of the data-memory port (512 bytes, 128 words).
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req, input, 1, access request, accepted only on a clk edge where ready=1.
REQ-005 SHALL have port we, input, 1: 1=store, 0=load.
REQ-006 SHALL have port funct3, input, 3, RISC-V width code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-007 SHALL have port addr, input, ADDR_W, byte address.
REQ-008 SHALL have port wdata, input, 32, store data; low byte/half/word used per funct3.
REQ-009 SHALL have port ready, output, 1, high only in IDLE.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, 32, extended load result.
REQ-012 SHALL have port fault, output, 1, valid with done: misaligned address or illegal funct3.
REQ-013 SHALL have ports mem_read and mem_write, outputs, 1 each, driving the data memory's MemRead/MemWrite.
REQ-014 SHALL have port mem_addr, output, ADDR_W, word-aligned byte address (bits [1:0]=0).
REQ-015 SHALL have port mem_wdata, output, 32, word written to memory.
REQ-016 SHALL have port mem_rdata, input, 32, combinational memory read word, valid in the same cycle as mem_read.

Function
REQ-017 SHALL implement states IDLE, RD, WR, DONE; all outputs registered or decoded from state only.
REQ-018 On acceptance SHALL latch we, funct3, addr, wdata; later changes to these inputs SHALL be ignored until IDLE.
REQ-019 Fault: halfword with addr[0]=1, word with addr[1:0]!=0, load funct3 in {011,110,111}, or store funct3 >= 011; IDLE->DONE, fault=1, no mem_read/mem_write cycle, rdata unchanged.
REQ-020 Loads: IDLE->RD->DONE; RD asserts mem_read=1 and captures mem_rdata at the RD-ending edge; done one cycle after RD.
REQ-021 Load extraction little-endian: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-022 SW: IDLE->WR->DONE, one WR cycle, mem_wdata=wdata.
REQ-023 SB/SH: IDLE->RD->WR->DONE (read-modify-write); WR word = captured word with addressed lane replaced by wdata[7:0] or wdata[15:0], other lanes unchanged.
REQ-024 mem_write SHALL be high exactly one cycle per store, with mem_addr and mem_wdata stable through that cycle; mem_read and mem_write SHALL never be high together.
REQ-025 mem_wdata SHALL be 0 outside WR; mem_addr SHALL hold the latched word address from RD/WR until the next acceptance.
REQ-026 DONE lasts one cycle (done=1, ready=0) then returns to IDLE; a held req is re-accepted no earlier than the cycle after DONE.
REQ-027 rdata SHALL update only on a successful load's DONE and hold otherwise; fault=0 on every non-fault done.

Reset
REQ-028 Reset SHALL force IDLE, ready=1, done=0, fault=0, rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0 at the next edge.
REQ-029 Reset mid-operation SHALL abandon the access; a RMW reset in RD SHALL never issue its write, and no done SHALL be produced.

Verification
REQ-030 Word 0x010=0x8899AABB; LB 0x012 -> rdata 0xFFFFFF99, done 2 cycles after acceptance; LBU 0x013 -> 0x00000088.
REQ-031 Then SB 0x011, wdata 0x12345677 -> one mem_read cycle, one mem_write cycle with mem_wdata 0x889977BB, done 3 cycles after acceptance.
REQ-032 SW 0x020 0xDEADBEEF, then LW 0x020 -> 0xDEADBEEF, LHU 0x022 -> 0x0000DEAD, LH 0x020 -> 0xFFFFBEEF.
REQ-033 LH 0x013 or load funct3=011 -> done and fault=1 one cycle after acceptance, no memory strobes, rdata unchanged.
REQ-034 SH 0x020 with reset asserted during RD -> no mem_write, ready=1 after release, word 0x020 still 0xDEADBEEF.
REQ-035 req held high over back-to-back LW -> each accepted only in IDLE, exactly one done per access, never mem_read with mem_write.
